set_ctrl: RTL and testbench

SET_CTRL -- requirements
Module: set_ctrl

---
 rtl/set_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_set_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_ctrl.sv
// Time/alarm setting controller: RUN / SET_TIME / SET_ALARM mode FSM driven by
// one-cycle button pulses, with an idle timeout that commits and returns to RUN.
module set_ctrl #(
    parameter int unsigned TIMEOUT     = 30,
    parameter int unsigned COUNTER_MAX = 86399
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [16:0] counter_state,
    input  logic        btn_mode,
    input  logic        btn_hour,
    input  logic        btn_min,
    input  logic        btn_alarm,
    output logic        set_flag,
    output logic [16:0] set_time,
    output logic        alarm_flag,
    output logic [16:0] alarm_time,
    output logic [1:0]  mode
);

    localparam int unsigned TW = 17;
    localparam int unsigned AW = 18;
    localparam int unsigned IW = 8;

    localparam logic [AW-1:0] MAX_A     = AW'(COUNTER_MAX);
    localparam logic [AW-1:0] WRAP_A    = AW'(COUNTER_MAX + 1);
    localparam logic [AW-1:0] HOUR_A    = AW'(3600);
    localparam logic [AW-1:0] MIN_A     = AW'(60);
    localparam logic [AW-1:0] MIN59_A   = AW'(3540);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        SET_TIME  = 2'b01,
        SET_ALARM = 2'b10,
        BAD       = 2'b11
    } mode_e;

    mode_e         mode_q,       mode_d;
    logic          set_flag_q,   set_flag_d;
    logic [TW-1:0] set_time_q,   set_time_d;
    logic          alarm_flag_q, alarm_flag_d;
    logic [TW-1:0] alarm_time_q, alarm_time_d;
    logic          alarm_en_q,   alarm_en_d;
    logic [TW-1:0] edit_q,       edit_d;
    logic [IW-1:0] idle_q,       idle_d;

    logic          any_btn;
    logic          timeout;
    logic [TW-1:0] floor_min;

    // +1 hour at 18 bits, wrapping past the last second of the day
    function automatic logic [TW-1:0] hour_inc(input logic [TW-1:0] v);
        logic [AW-1:0] s;
        s = AW'(v) + HOUR_A;
        if (s > MAX_A) begin
            s = s - WRAP_A;
        end
        return TW'(s);
    endfunction

    // +1 minute, minute field wraps 59 -> 0 without carrying into hours
    function automatic logic [TW-1:0] min_inc(input logic [TW-1:0] v);
        logic [AW-1:0] s;
        logic [AW-1:0] mins;
        mins = (AW'(v) / MIN_A) % MIN_A;
        if (mins == AW'(59)) begin
            s = AW'(v) - MIN59_A;
        end else begin
            s = AW'(v) + MIN_A;
        end
        if (s > MAX_A) begin
            s = s - WRAP_A;
        end
        return TW'(s);
    endfunction

    assign any_btn   = btn_mode | btn_hour | btn_min | btn_alarm;
    assign timeout   = !any_btn && (idle_q == IDLE_LAST);
    assign floor_min = TW'(AW'(counter_state) - (AW'(counter_state) % MIN_A));

    always_comb begin
        mode_d       = mode_q;
        set_flag_d   = set_flag_q;
        set_time_d   = set_time_q;
        alarm_flag_d = alarm_flag_q;
        alarm_time_d = alarm_time_q;
        alarm_en_d   = alarm_en_q;
        edit_d       = edit_q;
        idle_d       = idle_q;

        case (mode_q)
            RUN: begin
                idle_d = '0;
                if (btn_mode) begin
                    mode_d     = SET_TIME;
                    set_time_d = floor_min;
                    set_flag_d = 1'b1;
                end else if (btn_alarm) begin
                    alarm_en_d   = !alarm_en_q;
                    alarm_flag_d = !alarm_en_q;
                end
            end

            SET_TIME: begin
                if (any_btn) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
                if (btn_mode) begin
                    mode_d       = SET_ALARM;
                    set_flag_d   = 1'b0;
                    edit_d       = alarm_time_q;
                    alarm_flag_d = 1'b0;
                end else if (btn_hour) begin
                    set_time_d = hour_inc(set_time_q);
                end else if (btn_min) begin
                    set_time_d = min_inc(set_time_q);
                end else if (timeout) begin
                    mode_d     = RUN;
                    set_flag_d = 1'b0;
                    idle_d     = '0;
                end
            end

            SET_ALARM: begin
                if (any_btn) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
                // Both explicit exit and timeout commit the edited setpoint
                if (btn_mode || timeout) begin
                    mode_d       = RUN;
                    alarm_time_d = edit_q;
                    alarm_flag_d = alarm_en_q;
                    idle_d       = '0;
                end else if (btn_hour) begin
                    edit_d = hour_inc(edit_q);
                end else if (btn_min) begin
                    edit_d = min_inc(edit_q);
                end
            end

            default: begin
                mode_d     = RUN;
                set_flag_d = 1'b0;
                idle_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q       <= RUN;
            set_flag_q   <= 1'b0;
            set_time_q   <= '0;
            alarm_flag_q <= 1'b0;
            alarm_time_q <= '0;
            alarm_en_q   <= 1'b0;
            edit_q       <= '0;
            idle_q       <= '0;
        end else begin
            mode_q       <= mode_d;
            set_flag_q   <= set_flag_d;
            set_time_q   <= set_time_d;
            alarm_flag_q <= alarm_flag_d;
            alarm_time_q <= alarm_time_d;
            alarm_en_q   <= alarm_en_d;
            edit_q       <= edit_d;
            idle_q       <= idle_d;
        end
    end

    assign set_flag   = set_flag_q;
    assign set_time   = set_time_q;
    assign alarm_flag = alarm_flag_q;
    assign alarm_time = alarm_time_q;
    assign mode       = mode_q;

endmodule

// File: tb/tb_set_ctrl.sv
// Bench for set_ctrl: directed scenarios plus random button traffic checked
// against an hours/minutes/seconds reference model.
module tb_set_ctrl;

    localparam int TIMEOUT = 30;

    logic        clock;
    logic        reset;
    logic [16:0] counter_state;
    logic        btn_mode;
    logic        btn_hour;
    logic        btn_min;
    logic        btn_alarm;
    logic        set_flag;
    logic [16:0] set_time;
    logic        alarm_flag;
    logic [16:0] alarm_time;
    logic [1:0]  mode;

    int vectors;
    int miscompares;

    // Reference model state
    int m_mode;
    int m_set_time;
    int m_alarm_time;
    int m_edit;
    int m_quiet;
    bit m_set_flag;
    bit m_alarm_flag;
    bit m_alarm_en;

    set_ctrl #(.TIMEOUT(30), .COUNTER_MAX(86399)) dut (
        .clock        (clock),
        .reset        (reset),
        .counter_state(counter_state),
        .btn_mode     (btn_mode),
        .btn_hour     (btn_hour),
        .btn_min      (btn_min),
        .btn_alarm    (btn_alarm),
        .set_flag     (set_flag),
        .set_time     (set_time),
        .alarm_flag   (alarm_flag),
        .alarm_time   (alarm_time),
        .mode         (mode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int add_hour(input int v);
        int h;
        h = v / 3600;
        return ((h + 1) % 24) * 3600 + (v % 3600);
    endfunction

    function automatic int add_min(input int v);
        int h;
        int m;
        h = v / 3600;
        m = (v / 60) % 60;
        return h * 3600 + ((m + 1) % 60) * 60 + (v % 60);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_set_time = 0; m_alarm_time = 0; m_edit = 0; m_quiet = 0;
        m_set_flag = 0; m_alarm_flag = 0; m_alarm_en = 0;
    endtask

    task automatic model_step(input bit bm, input bit bh, input bit bn, input bit ba, input int cs);
        bit any;
        any = bm | bh | bn | ba;
        if (m_mode == 0) begin
            if (bm) begin
                m_mode = 1; m_set_time = (cs / 60) * 60; m_set_flag = 1; m_quiet = 0;
            end else if (ba) begin
                m_alarm_en = !m_alarm_en; m_alarm_flag = m_alarm_en;
            end
        end else begin
            if (!any) begin
                m_quiet++;
                if (m_quiet >= TIMEOUT) begin
                    if (m_mode == 2) begin
                        m_alarm_time = m_edit; m_alarm_flag = m_alarm_en;
                    end
                    m_set_flag = 0; m_mode = 0; m_quiet = 0;
                end
            end else begin
                m_quiet = 0;
                if (m_mode == 1) begin
                    if (bm) begin
                        m_mode = 2; m_set_flag = 0; m_edit = m_alarm_time; m_alarm_flag = 0;
                    end else if (bh) m_set_time = add_hour(m_set_time);
                    else if (bn) m_set_time = add_min(m_set_time);
                end else begin
                    if (bm) begin
                        m_mode = 0; m_alarm_time = m_edit; m_alarm_flag = m_alarm_en;
                    end else if (bh) m_edit = add_hour(m_edit);
                    else if (bn) m_edit = add_min(m_edit);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".mode"},       32'(mode),       32'(m_mode));
        chk({tag, ".set_flag"},   32'(set_flag),   32'(m_set_flag));
        chk({tag, ".set_time"},   32'(set_time),   32'(m_set_time));
        chk({tag, ".alarm_flag"}, 32'(alarm_flag), 32'(m_alarm_flag));
        chk({tag, ".alarm_time"}, 32'(alarm_time), 32'(m_alarm_time));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".mode"},       32'(mode),       32'd0);
        chk({tag, ".set_flag"},   32'(set_flag),   32'd0);
        chk({tag, ".set_time"},   32'(set_time),   32'd0);
        chk({tag, ".alarm_flag"}, 32'(alarm_flag), 32'd0);
        chk({tag, ".alarm_time"}, 32'(alarm_time), 32'd0);
    endtask

    // Called just after a negedge; leaves the bench just after the next negedge
    task automatic step(input bit bm, input bit bh, input bit bn, input bit ba, input int cs, input string tag);
        btn_mode = bm; btn_hour = bh; btn_min = bn; btn_alarm = ba;
        counter_state = 17'(cs);
        @(posedge clock);
        model_step(bm, bh, bn, ba, cs);
        #1;
        btn_mode = 0; btn_hour = 0; btn_min = 0; btn_alarm = 0;
        check_model(tag);
        @(negedge clock);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 12345, tag);
    endtask

    // Asynchronous reset taken between clock edges
    task automatic do_reset(input string tag);
        reset = 1'b1;
        btn_mode = 0; btn_hour = 0; btn_min = 0; btn_alarm = 0;
        #1;
        model_reset();
        check_zero({tag, ".async"});
        @(posedge clock);
        #1;
        check_model({tag, ".hold"});
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic rand_step(input int pct, input string tag);
        int r;
        int k;
        bit bm, bh, bn, ba;
        bm = 0; bh = 0; bn = 0; ba = 0;
        r = int'($urandom_range(0, 99));
        if (r < pct) begin
            k = int'($urandom_range(0, 9));
            case (k)
                0, 1: bm = 1;
                2, 3: bh = 1;
                4, 5: bn = 1;
                6, 7: ba = 1;
                8: begin bm = 1; bh = 1; bn = 1; end
                default: begin bh = 1; bn = 1; ba = 1; end
            endcase
        end
        step(bm, bh, bn, ba, int'($urandom_range(0, 86399)), tag);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        counter_state = '0;
        btn_mode = 0; btn_hour = 0; btn_min = 0; btn_alarm = 0;
        model_reset();
        @(negedge clock);
        do_reset("init");

        // Entering SET_TIME zeroes the seconds of the live time
        step(1, 0, 0, 0, 34953, "enter_set");
        chk("enter_set.mode_c", 32'(mode), 32'd1);
        chk("enter_set.flag_c", 32'(set_flag), 32'd1);
        chk("enter_set.time_c", 32'(set_time), 32'd34920);

        // Minute wrap without hour carry, then hour wrap past midnight
        do_reset("r2");
        step(1, 0, 0, 0, 86399, "late");
        chk("late.time_c", 32'(set_time), 32'd86340);
        step(0, 0, 1, 0, 0, "min_wrap");
        chk("min_wrap.time_c", 32'(set_time), 32'd82800);
        for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0, "min_run");
        chk("min_run.time_c", 32'(set_time), 32'd86340);
        step(0, 1, 0, 0, 0, "hour_wrap");
        chk("hour_wrap.time_c", 32'(set_time), 32'd3540);

        // Mode beats hour in the same cycle
        step(1, 1, 0, 0, 0, "prio");
        chk("prio.mode_c", 32'(mode), 32'd2);
        chk("prio.time_c", 32'(set_time), 32'd3540);
        chk("prio.flag_c", 32'(set_flag), 32'd0);

        // Alarm set to 14:00, then armed from RUN
        do_reset("r3");
        step(1, 0, 0, 0, 0, "a_m1");
        step(1, 0, 0, 0, 0, "a_m2");
        for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0, "a_hour");
        step(1, 0, 0, 0, 0, "a_commit");
        chk("a_commit.mode_c", 32'(mode), 32'd0);
        chk("a_commit.atime_c", 32'(alarm_time), 32'd50400);
        chk("a_commit.aflag_c", 32'(alarm_flag), 32'd0);
        step(0, 0, 0, 1, 0, "a_arm");
        chk("a_arm.mode_c", 32'(mode), 32'd0);
        chk("a_arm.atime_c", 32'(alarm_time), 32'd50400);
        chk("a_arm.aflag_c", 32'(alarm_flag), 32'd1);

        // Timeout from SET_TIME leaves the alarm untouched
        step(1, 0, 0, 0, 600, "t_enter");
        idle(TIMEOUT - 1, "t_wait");
        chk("t_wait.mode_c", 32'(mode), 32'd1);
        idle(1, "t_exit");
        chk("t_exit.mode_c", 32'(mode), 32'd0);
        chk("t_exit.flag_c", 32'(set_flag), 32'd0);
        chk("t_exit.aflag_c", 32'(alarm_flag), 32'd1);

        // Timeout from SET_ALARM commits the edit and re-arms
        step(1, 0, 0, 0, 600, "ta_m1");
        step(1, 0, 0, 0, 600, "ta_m2");
        chk("ta_m2.aflag_c", 32'(alarm_flag), 32'd0);
        step(0, 0, 1, 0, 0, "ta_min");
        idle(TIMEOUT - 1, "ta_wait");
        chk("ta_wait.mode_c", 32'(mode), 32'd2);
        idle(1, "ta_exit");
        chk("ta_exit.mode_c", 32'(mode), 32'd0);
        chk("ta_exit.aflag_c", 32'(alarm_flag), 32'd1);
        chk("ta_exit.atime_c", 32'(alarm_time), 32'd50460);

        // Reset mid-edit, then the first button is honoured
        do_reset("r4");
        step(1, 0, 0, 0, 0, "e_m1");
        step(1, 0, 0, 0, 0, "e_m2");
        step(0, 1, 0, 0, 0, "e_hour");
        do_reset("mid_edit");
        step(1, 0, 0, 0, 7265, "post_rst");
        chk("post_rst.mode_c", 32'(mode), 32'd1);
        chk("post_rst.time_c", 32'(set_time), 32'd7260);
        step(1, 0, 0, 0, 0, "post_m2");
        step(1, 0, 0, 0, 0, "post_m3");
        chk("post_m3.atime_c", 32'(alarm_time), 32'd0);

        // Random traffic: busy phase, then sparse phase so timeouts occur
        for (int i = 0; i < 1200; i++) rand_step(40, "rnd_busy");
        for (int i = 0; i < 1500; i++) rand_step(3, "rnd_sparse");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
